// File: rtl/fence_sequencer_if.sv
// cache_control_if: handshake bundle between the pipeline and the caches/TLBs.
//   pipeline modport : drives the clear/flush/fence request lines, samples dones
//   cache modport    : the cache/TLB side of the same handshakes
// dcache_reserve/dcache_exclusive travel with the bundle but are owned by the
// load/store side, not by the fence sequencer.
interface cache_control_if;
  logic icache_clear;
  logic icache_flush;
  logic dcache_clear;
  logic dcache_flush;
  logic itlb_fence;
  logic dtlb_fence;
  logic dflush_done;
  logic iclear_done;
  logic itlb_fence_done;
  logic dtlb_fence_done;
  logic dcache_reserve;
  logic dcache_exclusive;

  modport pipeline (
    output icache_clear, icache_flush, dcache_clear, dcache_flush,
    output itlb_fence, dtlb_fence,
    input  dflush_done, iclear_done, itlb_fence_done, dtlb_fence_done
  );

  modport cache (
    input  icache_clear, icache_flush, dcache_clear, dcache_flush,
    input  itlb_fence, dtlb_fence, dcache_reserve, dcache_exclusive,
    output dflush_done, iclear_done, itlb_fence_done, dtlb_fence_done
  );
endinterface

// File: rtl/fence_sequencer.sv
// fence_sequencer: turns FENCE / FENCE.I / SFENCE.VMA requests from execute
// into an ordered DFLUSH -> ICLEAR -> TLB handshake sequence on cache_control_if
// and reports completion (or a per-phase watchdog timeout) to the hazard unit.
// Ports:
//   CLK, nRST       clock, asynchronous active-low reset
//   fence_req       FENCE request, level, held until fence_done
//   fence_i_req     FENCE.I request, level, held until fence_done
//   sfence_vma_req  SFENCE.VMA request, level, held until fence_done
//   cc_if           cache_control_if.pipeline handshake bundle
//   busy            sequence in progress (stall fetch/decode)
//   fence_done      one-cycle completion pulse
//   fence_err       one-cycle pulse with fence_done when a phase timed out
module fence_sequencer #(
  parameter bit          DCACHE_PRESENT  = 1'b1,
  parameter bit          ICACHE_PRESENT  = 1'b1,
  parameter bit          TLB_PRESENT     = 1'b1,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             fence_req,
  input  logic             fence_i_req,
  input  logic             sfence_vma_req,
  cache_control_if.pipeline cc_if,
  output logic             busy,
  output logic             fence_done,
  output logic             fence_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DFLUSH = 3'd1;
  localparam logic [2:0] S_ICLEAR = 3'd2;
  localparam logic [2:0] S_TLB    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam bit          WD_EN       = (WATCHDOG_CYCLES != 0);
  localparam int unsigned WDW         = WD_EN ? $clog2(WATCHDOG_CYCLES + 1) : 1;
  localparam int unsigned WD_LAST_INT = WD_EN ? WATCHDOG_CYCLES - 1 : 0;
  localparam int unsigned WD_ONE_INT  = 1;
  localparam logic [WDW-1:0] WD_LAST  = WD_LAST_INT[WDW-1:0];
  localparam logic [WDW-1:0] WD_ONE   = WD_ONE_INT[WDW-1:0];

  logic [2:0]     state_q, state_d;
  logic           pend_dc_q, pend_dc_d;
  logic           pend_ic_q, pend_ic_d;
  logic           pend_tlb_q, pend_tlb_d;
  logic           holdoff_q, holdoff_d;
  logic           iseen_q, iseen_d;
  logic           dseen_q, dseen_d;
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           dflush_q, dflush_d;
  logic           iclear_q, iclear_d;
  logic           itlb_q, itlb_d;
  logic           dtlb_q, dtlb_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           any_req_s, req_dc_s, req_ic_s, req_tlb_s;
  logic           wd_expire_s, i_all_s, d_all_s;

  // First phase (in DFLUSH, ICLEAR, TLB order) whose flag is set, else DONE.
  function automatic logic [2:0] first_phase(input logic dc, input logic ic, input logic tlb);
    logic [2:0] s;
    if (dc) begin
      s = S_DFLUSH;
    end else if (ic) begin
      s = S_ICLEAR;
    end else if (tlb) begin
      s = S_TLB;
    end else begin
      s = S_DONE;
    end
    return s;
  endfunction

  assign any_req_s   = fence_req | fence_i_req | sfence_vma_req;
  assign req_dc_s    = DCACHE_PRESENT & (fence_req | fence_i_req);
  assign req_ic_s    = ICACHE_PRESENT & fence_i_req;
  assign req_tlb_s   = TLB_PRESENT & sfence_vma_req;
  assign wd_expire_s = WD_EN && (wd_cnt_q == WD_LAST);
  // TLB done flags are sticky: a done seen earlier in the phase still counts.
  assign i_all_s     = iseen_q | cc_if.itlb_fence_done;
  assign d_all_s     = dseen_q | cc_if.dtlb_fence_done;

  // Next-state, pending-flag, watchdog and output-register computation.
  always_comb begin
    state_d    = state_q;
    pend_dc_d  = pend_dc_q;
    pend_ic_d  = pend_ic_q;
    pend_tlb_d = pend_tlb_q;
    holdoff_d  = 1'b0;
    iseen_d    = iseen_q;
    dseen_d    = dseen_q;
    wd_cnt_d   = wd_cnt_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // holdoff_q covers the cycle after DONE, when a stale request may still be high.
        if (!holdoff_q && any_req_s) begin
          pend_dc_d  = req_dc_s;
          pend_ic_d  = req_ic_s;
          pend_tlb_d = req_tlb_s;
          state_d    = first_phase(req_dc_s, req_ic_s, req_tlb_s);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DFLUSH: begin
        if (cc_if.dflush_done) begin
          pend_dc_d = 1'b0;
          state_d   = first_phase(1'b0, pend_ic_q, pend_tlb_q);
        end else if (wd_expire_s) begin
          pend_dc_d  = 1'b0;
          pend_ic_d  = 1'b0;
          pend_tlb_d = 1'b0;
          err_d      = 1'b1;
          state_d    = S_DONE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_ONE;
        end
      end
      S_ICLEAR: begin
        if (cc_if.iclear_done) begin
          pend_ic_d = 1'b0;
          state_d   = first_phase(1'b0, 1'b0, pend_tlb_q);
        end else if (wd_expire_s) begin
          pend_dc_d  = 1'b0;
          pend_ic_d  = 1'b0;
          pend_tlb_d = 1'b0;
          err_d      = 1'b1;
          state_d    = S_DONE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_ONE;
        end
      end
      S_TLB: begin
        iseen_d = i_all_s;
        dseen_d = d_all_s;
        if (i_all_s && d_all_s) begin
          pend_tlb_d = 1'b0;
          state_d    = S_DONE;
        end else if (wd_expire_s) begin
          pend_dc_d  = 1'b0;
          pend_ic_d  = 1'b0;
          pend_tlb_d = 1'b0;
          err_d      = 1'b1;
          state_d    = S_DONE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_ONE;
        end
      end
      S_DONE: begin
        // DONE is held until the fence_done pulse has actually been emitted;
        // the direct IDLE->DONE path therefore spends one extra cycle here.
        if (done_q) begin
          state_d   = S_IDLE;
          holdoff_d = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        pend_dc_d  = 1'b0;
        pend_ic_d  = 1'b0;
        pend_tlb_d = 1'b0;
      end
    endcase

    // Watchdog and sticky TLB flags restart on every phase entry.
    if (state_d != state_q) begin
      wd_cnt_d = '0;
      iseen_d  = 1'b0;
      dseen_d  = 1'b0;
    end else begin
      wd_cnt_d = wd_cnt_d;
    end

    dflush_d = (state_d == S_DFLUSH);
    iclear_d = (state_d == S_ICLEAR);
    itlb_d   = (state_d == S_TLB) && !iseen_d;
    dtlb_d   = (state_d == S_TLB) && !dseen_d;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE) && (state_q != S_IDLE);
  end

  // State, flags, watchdog counter and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      pend_dc_q  <= 1'b0;
      pend_ic_q  <= 1'b0;
      pend_tlb_q <= 1'b0;
      holdoff_q  <= 1'b0;
      iseen_q    <= 1'b0;
      dseen_q    <= 1'b0;
      wd_cnt_q   <= '0;
      dflush_q   <= 1'b0;
      iclear_q   <= 1'b0;
      itlb_q     <= 1'b0;
      dtlb_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_dc_q  <= pend_dc_d;
      pend_ic_q  <= pend_ic_d;
      pend_tlb_q <= pend_tlb_d;
      holdoff_q  <= holdoff_d;
      iseen_q    <= iseen_d;
      dseen_q    <= dseen_d;
      wd_cnt_q   <= wd_cnt_d;
      dflush_q   <= dflush_d;
      iclear_q   <= iclear_d;
      itlb_q     <= itlb_d;
      dtlb_q     <= dtlb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cc_if.dcache_flush = dflush_q;
  assign cc_if.icache_clear = iclear_q;
  assign cc_if.itlb_fence   = itlb_q;
  assign cc_if.dtlb_fence   = dtlb_q;
  assign cc_if.icache_flush = 1'b0;
  assign cc_if.dcache_clear = 1'b0;
  assign busy               = busy_q;
  assign fence_done         = done_q;
  assign fence_err          = err_q;

endmodule

// File: tb/tb_fence_sequencer.sv
// Directed bench for fence_sequencer: a table of per-cycle {requests, dones,
// expected outputs} for the normal sequences, plus hand-written watchdog,
// asynchronous-reset and no-dcache sequences.
module tb_fence_sequencer;
  logic clk = 1'b0;
  logic nrst;
  logic fe_a, fi_a, sf_a;
  logic fe_b, fi_b, sf_b;
  logic busy_a, done_a, err_a;
  logic busy_b, done_b, err_b;
  int   checks = 0;
  int   errors = 0;

  cache_control_if cc_a();
  cache_control_if cc_b();

  fence_sequencer #(.WATCHDOG_CYCLES(8)) dut_a (
    .CLK(clk), .nRST(nrst), .fence_req(fe_a), .fence_i_req(fi_a), .sfence_vma_req(sf_a),
    .cc_if(cc_a), .busy(busy_a), .fence_done(done_a), .fence_err(err_a));

  fence_sequencer #(.DCACHE_PRESENT(1'b0)) dut_b (
    .CLK(clk), .nRST(nrst), .fence_req(fe_b), .fence_i_req(fi_b), .sfence_vma_req(sf_b),
    .cc_if(cc_b), .busy(busy_b), .fence_done(done_b), .fence_err(err_b));

  always #5 clk = ~clk;

  // Observed: {busy, fence_done, fence_err, icache_clear, icache_flush,
  //            dcache_clear, dcache_flush, itlb_fence, dtlb_fence}
  logic [8:0] obs_a, obs_b;
  assign obs_a = {busy_a, done_a, err_a, cc_a.icache_clear, cc_a.icache_flush,
                  cc_a.dcache_clear, cc_a.dcache_flush, cc_a.itlb_fence, cc_a.dtlb_fence};
  assign obs_b = {busy_b, done_b, err_b, cc_b.icache_clear, cc_b.icache_flush,
                  cc_b.dcache_clear, cc_b.dcache_flush, cc_b.itlb_fence, cc_b.dtlb_fence};

  localparam logic [8:0] E_IDLE = 9'b000_000000;
  localparam logic [8:0] E_BUSY = 9'b100_000000;
  localparam logic [8:0] E_DFL  = 9'b100_000100;
  localparam logic [8:0] E_ICL  = 9'b100_100000;
  localparam logic [8:0] E_TLB2 = 9'b100_000011;
  localparam logic [8:0] E_ITLB = 9'b100_000010;
  localparam logic [8:0] E_DONE = 9'b110_000000;
  localparam logic [8:0] E_ERR  = 9'b111_000000;

  // Request encoding {fence, fence_i, sfence_vma}; done encoding {dflush, iclear, itlb, dtlb}
  localparam logic [2:0] R_NO  = 3'b000;
  localparam logic [2:0] R_FE  = 3'b100;
  localparam logic [2:0] R_FI  = 3'b010;
  localparam logic [2:0] R_SF  = 3'b001;
  localparam logic [2:0] R_ALL = 3'b111;
  localparam logic [3:0] D_NO  = 4'b0000;
  localparam logic [3:0] D_DF  = 4'b1000;
  localparam logic [3:0] D_IC  = 4'b0100;
  localparam logic [3:0] D_IT  = 4'b0010;
  localparam logic [3:0] D_DT  = 4'b0001;

  typedef struct {
    logic [2:0] req;
    logic [3:0] dn;
    logic [8:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [2:0] req, input logic [3:0] dn, input logic [8:0] exp);
    vec_t v;
    v.req = req;
    v.dn  = dn;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // One cycle on DUT A: drive just after the edge, return at mid-cycle for sampling.
  task automatic step(input logic [2:0] req, input logic [3:0] dn);
    @(posedge clk);
    #1;
    {fe_a, fi_a, sf_a} = req;
    {cc_a.dflush_done, cc_a.iclear_done, cc_a.itlb_fence_done, cc_a.dtlb_fence_done} = dn;
    @(negedge clk);
  endtask

  task automatic step_b(input logic [2:0] req);
    @(posedge clk);
    #1;
    {fe_b, fi_b, sf_b} = req;
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0;
    {fe_a, fi_a, sf_a} = R_NO;
    {fe_b, fi_b, sf_b} = R_NO;
    {cc_a.dflush_done, cc_a.iclear_done, cc_a.itlb_fence_done, cc_a.dtlb_fence_done} = D_NO;
    {cc_b.dflush_done, cc_b.iclear_done, cc_b.itlb_fence_done, cc_b.dtlb_fence_done} = D_NO;
    cc_a.dcache_reserve = 1'b0; cc_a.dcache_exclusive = 1'b0;
    cc_b.dcache_reserve = 1'b0; cc_b.dcache_exclusive = 1'b0;

    // FENCE.I: dflush_done in cycle 6, iclear_done in cycle 10, stale request in cycle 12
    add(R_FI, D_NO, E_IDLE);
    for (int i = 1; i <= 5; i++) add(R_FI, D_NO, E_DFL);
    add(R_FI, D_DF, E_DFL);
    for (int i = 7; i <= 9; i++) add(R_FI, D_NO, E_ICL);
    add(R_FI, D_IC, E_ICL);
    add(R_FI, D_NO, E_DONE);
    add(R_FI, D_NO, E_IDLE);
    add(R_NO, D_NO, E_IDLE);
    // SFENCE.VMA: dtlb done cycle 2, itlb done cycle 6, foreign dones ignored in cycle 4
    add(R_SF, D_NO, E_IDLE);
    add(R_SF, D_NO, E_TLB2);
    add(R_SF, D_DT, E_TLB2);
    add(R_SF, D_NO, E_ITLB);
    add(R_SF, D_DF | D_IC, E_ITLB);
    add(R_SF, D_NO, E_ITLB);
    add(R_SF, D_IT, E_ITLB);
    add(R_SF, D_NO, E_DONE);
    add(R_NO, D_NO, E_IDLE);
    // All three merged: DFLUSH, ICLEAR (done already high on entry), TLB, one fence_done
    add(R_ALL, D_NO, E_IDLE);
    add(R_ALL, D_NO, E_DFL);
    add(R_ALL, D_DF | D_IC, E_DFL);
    add(R_ALL, D_IC | D_IT | D_DT, E_ICL);
    add(R_ALL, D_DT, E_TLB2);
    add(R_ALL, D_IT, E_ITLB);
    add(R_ALL, D_NO, E_DONE);
    add(R_NO, D_NO, E_IDLE);
    add(R_NO, D_NO, E_IDLE);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", obs_a, E_IDLE);
    check("reset_b", obs_b, E_IDLE);
    nrst = 1'b1;
    @(negedge clk);
    check("post_reset_a", obs_a, E_IDLE);

    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].dn);
      check($sformatf("vec[%0d]", i), obs_a, vecs[i].exp);
    end

    // Watchdog: dflush_done never arrives, 8 cycles of dcache_flush then abort
    step(R_FE, D_NO);
    check("wd_c0", obs_a, E_IDLE);
    for (int c = 1; c <= 8; c++) begin
      step(R_FE, D_NO);
      check($sformatf("wd_c%0d", c), obs_a, E_DFL);
    end
    step(R_FE, D_NO);
    check("wd_abort", obs_a, E_ERR);
    step(R_NO, D_NO);
    check("wd_idle", obs_a, E_IDLE);
    step(R_NO, D_NO);
    check("wd_idle2", obs_a, E_IDLE);

    // Asynchronous reset in the middle of ICLEAR
    step(R_FI, D_NO);
    check("rst_c0", obs_a, E_IDLE);
    step(R_FI, D_DF);
    check("rst_c1", obs_a, E_DFL);
    step(R_FI, D_NO);
    check("rst_c2", obs_a, E_ICL);
    #2;
    nrst = 1'b0;
    {fe_a, fi_a, sf_a} = R_NO;
    #1;
    check("rst_async", obs_a, E_IDLE);
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(R_NO, D_NO);
      check($sformatf("rst_after%0d", c), obs_a, E_IDLE);
    end

    // No dcache: FENCE completes in cycle 2, stale request in cycle 3 ignored
    step_b(R_FE);
    check("nodc_c0", obs_b, E_IDLE);
    step_b(R_FE);
    check("nodc_c1", obs_b, E_BUSY);
    step_b(R_FE);
    check("nodc_c2", obs_b, E_DONE);
    step_b(R_FE);
    check("nodc_c3", obs_b, E_IDLE);
    step_b(R_NO);
    check("nodc_c4", obs_b, E_IDLE);
    step_b(R_NO);
    check("nodc_c5", obs_b, E_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
